// File: rtl/led_blink_sequencer.sv
// LED blink sequencer.
// Turns a one-cycle start request into N timed LED pulses. Each pulse is
// ON_CYCLES cycles lit followed by OFF_CYCLES cycles dark. A one-cycle
// o_done pulse marks normal completion. i_abort cancels a running sequence
// without a done pulse.
module led_blink_sequencer #(
    parameter int unsigned ON_CYCLES  = 6250000,
    parameter int unsigned OFF_CYCLES = 6250000,
    parameter int unsigned COUNT_W    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [COUNT_W-1:0] i_count,
    input  logic               i_abort,
    output logic               o_led,
    output logic               o_busy,
    output logic               o_done
);

    // The timer is wide enough to hold the longer of the two phase lengths.
    localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);

    // The timer counts down to zero; the phase ends at the edge where it
    // reads zero. Loading N-1 therefore gives a phase exactly N cycles long.
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = '0;
    localparam logic [COUNT_W-1:0] COUNT_ZERO = '0;
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State, timer, blink counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic. The output values computed here are the ones the
    // registers will show in the cycle after the edge, so every branch sets
    // led/busy/done for the state it is entering.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        led_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Abort takes priority: a simultaneous start is dropped.
                if (i_start && !i_abort) begin
                    remaining_d = i_count;
                    if (i_count != COUNT_ZERO) begin
                        state_d = ST_ON;
                        timer_d = ON_LOAD;
                        led_d   = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        // Zero-length request completes immediately.
                        done_d = 1'b1;
                    end
                end
            end

            ST_ON: begin
                if (i_abort) begin
                    state_d     = ST_IDLE;
                    timer_d     = TIMER_ZERO;
                    remaining_d = COUNT_ZERO;
                end else if (timer_q == TIMER_ZERO) begin
                    // One blink finished lighting; account for it now so the
                    // OFF phase knows whether another blink follows.
                    state_d     = ST_OFF;
                    timer_d     = OFF_LOAD;
                    remaining_d = remaining_q - COUNT_ONE;
                    busy_d      = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                    led_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            ST_OFF: begin
                if (i_abort) begin
                    state_d     = ST_IDLE;
                    timer_d     = TIMER_ZERO;
                    remaining_d = COUNT_ZERO;
                end else if (timer_q == TIMER_ZERO) begin
                    if (remaining_q != COUNT_ZERO) begin
                        // Next blink starts with no idle gap.
                        state_d = ST_ON;
                        timer_d = ON_LOAD;
                        led_d   = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                timer_d     = TIMER_ZERO;
                remaining_d = COUNT_ZERO;
            end
        endcase
    end

    assign o_led  = led_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench for led_blink_sequencer: directed scenarios followed by random
// traffic, scored against a timeline model of the blink sequence.
module tb_led_blink_sequencer;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int PER = ON + OFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic       abort = 1'b0;
    logic       led, busy, done;

    led_blink_sequencer #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .COUNT_W   (4)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_count(count),
        .i_abort(abort),
        .o_led  (led),
        .o_busy (busy),
        .o_done (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   tag;
        logic led;
        logic busy;
        logic done;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Model: a run is described by its start edge and blink count; outputs
    // follow from elapsed edges since the start using the blink period.
    bit m_act = 0;
    int m_k   = 0;
    int m_n   = 0;
    int m_e   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input logic r, input logic s, input logic [3:0] c, input logic a);
        exp_t x;
        int   el;
        rst = r; start = s; count = c; abort = a;
        m_e = m_e + 1;
        x.tag = m_e; x.led = 1'b0; x.busy = 1'b0; x.done = 1'b0;
        if (r) begin
            m_act = 0;
        end else if (m_act) begin
            el = m_e - m_k;
            if (a) begin
                m_act = 0;
            end else if (el < m_n * PER) begin
                x.busy = 1'b1;
                x.led  = ((el % PER) < ON);
            end else begin
                x.done = 1'b1;
                m_act  = 0;
            end
        end else if (s && !a) begin
            if (c != 4'd0) begin
                m_act = 1; m_k = m_e; m_n = int'(c);
                x.led = 1'b1; x.busy = 1'b1;
            end else begin
                x.done = 1'b1;
            end
        end
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    // Monitor: compare every registered output once its edge has passed.
    always @(negedge clk) begin
        exp_t x;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            x = q.pop_front();
            total = total + 1;
            if (led !== x.led) begin
                bad = bad + 1;
                $display("FAIL led cyc=%0d got=%b want=%b", x.tag, led, x.led);
            end
            total = total + 1;
            if (busy !== x.busy) begin
                bad = bad + 1;
                $display("FAIL busy cyc=%0d got=%b want=%b", x.tag, busy, x.busy);
            end
            total = total + 1;
            if (done !== x.done) begin
                bad = bad + 1;
                $display("FAIL done cyc=%0d got=%b want=%b", x.tag, done, x.done);
            end
        end
    end

    initial begin
        // Reset
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        idle(2);
        // Two blinks
        step(1'b0, 1'b1, 4'd2, 1'b0);
        idle(13);
        // Zero-count request
        step(1'b0, 1'b1, 4'd0, 1'b0);
        idle(4);
        // Start while busy is ignored
        step(1'b0, 1'b1, 4'd3, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 4'd5, 1'b0);
        idle(14);
        // Abort in second cycle of first OFF, then restart
        step(1'b0, 1'b1, 4'd2, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        idle(1);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        idle(7);
        // Abort together with start in idle
        step(1'b0, 1'b1, 4'd3, 1'b1);
        idle(2);
        // Reset during ON, start held through reset
        step(1'b0, 1'b1, 4'd4, 1'b0);
        idle(6);
        step(1'b1, 1'b1, 4'd4, 1'b0);
        step(1'b1, 1'b1, 4'd4, 1'b0);
        step(1'b1, 1'b1, 4'd4, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        idle(7);
        // Fifteen blinks, back-to-back restart in the done cycle
        step(1'b0, 1'b1, 4'd15, 1'b0);
        idle(75);
        step(1'b0, 1'b1, 4'd15, 1'b0);
        idle(77);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 40) == 0));
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        idle(3);
        @(negedge clk);
        @(negedge clk);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d want=finished", cyc);
        $fatal(1);
    end

endmodule
